hazard_ctrl: RTL and testbench

- Hazard control unit for the 16-bit 5-stage pipeline.
- Generates the stall (dhazard) and flush (chazard) controls consumed by the IF/ID pipeline register. Also generates the matching PC-hold and ID/EX-bubble controls.
- Detects load-use data hazards, taken branches resolved in EX, and multicycle EX operations.
- Sequences multi-cycle flushes and waits with a small FSM, and keeps saturating performance counters.

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage pipeline with flush/multicycle sequencing and perf counters
module hazard_ctrl #(
  parameter int REG_AW       = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic              branch_taken,
  input  logic              mc_start,
  input  logic              mc_done,
  output logic              dhazard,
  output logic              chazard,
  output logic              pc_hold,
  output logic              idex_bubble,
  output logic              mc_error,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MCWAIT = 2'd2} state_t;
  localparam logic [3:0] REM_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [9:0] TO_LAST    = 10'(MC_TIMEOUT - 2);
  state_t           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [9:0]       to_q, to_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             load_use;
  assign load_use = ex_is_load & ex_regwrite & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    to_d        = to_q;
    err_d       = err_q;
    dhazard     = 1'b0;
    chazard     = 1'b0;
    pc_hold     = 1'b0;
    idex_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          chazard     = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            rem_d   = REM_RELOAD;
          end
        end else if (mc_start) begin
          if (!mc_done) begin
            dhazard = 1'b1;
            pc_hold = 1'b1;
            state_d = MCWAIT;
            to_d    = '0;
          end
        end else if (load_use) begin
          dhazard     = 1'b1;
          pc_hold     = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      FLUSH: begin
        chazard     = 1'b1;
        idex_bubble = 1'b1;
        if (branch_taken) rem_d = REM_RELOAD;
        else if (rem_q <= 4'd1) state_d = RUN;
        else rem_d = rem_q - 4'd1;
      end
      MCWAIT: begin
        if (mc_done) state_d = RUN;
        else begin
          dhazard = 1'b1;
          pc_hold = 1'b1;
          to_d    = to_q + 10'd1;
          // exit on the cycle where the counter steps onto MC_TIMEOUT-1
          if (to_q >= TO_LAST) begin
            err_d   = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
    if (reset) {dhazard, chazard, pc_hold, idex_bubble} = 4'b0;
    stall_d = (dhazard && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    flush_d = (chazard && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      rem_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      to_q    <= to_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign mc_error  = err_q;
  assign state_o   = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load;
  logic       branch_taken, mc_start, mc_done;
  logic       dhazard, chazard, pc_hold, idex_bubble, mc_error;
  logic [1:0] state_o;
  logic [3:0] stall_cnt, flush_cnt;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.REG_AW(3), .FLUSH_CYCLES(2), .MC_TIMEOUT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
    .mc_start(mc_start), .mc_done(mc_done), .dhazard(dhazard), .chazard(chazard),
    .pc_hold(pc_hold), .idex_bubble(idex_bubble), .mc_error(mc_error),
    .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load} = '0;
    {branch_taken, mc_start, mc_done} = '0;
  endtask
  task automatic set_load_use(input logic [2:0] rd);
    ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_rd = rd; id_use_rs2 = 1'b1; id_rs2 = rd;
  endtask
  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    branch_taken = 1'b1;
    #1;
    chk("rst_chazard_forced", chazard, 0);
    chk("rst_state", state_o, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_mc_error", mc_error, 0);
    idle();
    step();
    reset = 1'b0;
    step();
    set_load_use(3'd3);
    #1;
    chk("lu_dhazard", dhazard, 1);
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_bubble", idex_bubble, 1);
    chk("lu_chazard", chazard, 0);
    step();
    idle();
    #1;
    chk("lu_one_cycle", dhazard, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_state", state_o, 0);
    set_load_use(3'd0);
    #1;
    chk("lu_r0_no_stall", dhazard, 0);
    idle();
    ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 3'd5; id_rs1 = 3'd5;
    #1;
    chk("lu_unused_rs1", dhazard, 0);
    id_use_rs1 = 1'b1;
    #1;
    chk("lu_rs1_match", dhazard, 1);
    ex_regwrite = 1'b0;
    #1;
    chk("lu_no_regwrite", dhazard, 0);
    idle();
    set_load_use(3'd3);
    branch_taken = 1'b1;
    #1;
    chk("prio_chazard", chazard, 1);
    chk("prio_dhazard", dhazard, 0);
    chk("prio_bubble", idex_bubble, 1);
    chk("prio_pc_hold", pc_hold, 0);
    step();
    idle();
    chk("br_state_flush", state_o, 1);
    chk("br_chazard2", chazard, 1);
    chk("br_dhazard2", dhazard, 0);
    chk("br_flush_cnt1", flush_cnt, 1);
    step();
    chk("br_state_run", state_o, 0);
    chk("br_chazard_off", chazard, 0);
    chk("br_flush_cnt2", flush_cnt, 2);
    branch_taken = 1'b1;
    step();
    #1;
    chk("br2_reload_chazard", chazard, 1);
    step();
    branch_taken = 1'b0;
    #1;
    chk("br2_third_state", state_o, 1);
    chk("br2_third_chazard", chazard, 1);
    step();
    chk("br2_done_state", state_o, 0);
    chk("br2_done_chazard", chazard, 0);
    chk("br2_flush_cnt", flush_cnt, 5);
    mc_start = 1'b1;
    #1;
    chk("mc_dhazard0", dhazard, 1);
    chk("mc_pc_hold0", pc_hold, 1);
    chk("mc_bubble0", idex_bubble, 0);
    step();
    mc_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      branch_taken = (i == 1);
      #1;
      chk("mc_wait_dhazard", dhazard, 1);
      chk("mc_wait_state", state_o, 2);
      chk("mc_wait_no_flush", chazard, 0);
      step();
    end
    branch_taken = 1'b0;
    mc_done = 1'b1;
    #1;
    chk("mc_done_dhazard", dhazard, 0);
    chk("mc_done_pc_hold", pc_hold, 0);
    step();
    mc_done = 1'b0;
    chk("mc_back_run", state_o, 0);
    chk("mc_stall_cnt", stall_cnt, 6);
    mc_start = 1'b1;
    mc_done = 1'b1;
    #1;
    chk("mc_same_cycle", dhazard, 0);
    step();
    idle();
    chk("mc_same_state", state_o, 0);
    chk("mc_same_cnt", stall_cnt, 6);
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("to_wait_dhazard", dhazard, 1);
      chk("to_wait_state", state_o, 2);
      step();
    end
    chk("to_state_run", state_o, 0);
    chk("to_mc_error", mc_error, 1);
    chk("to_dhazard_off", dhazard, 0);
    chk("to_stall_cnt", stall_cnt, 14);
    set_load_use(3'd4);
    step();
    step();
    idle();
    #1;
    chk("sat_stall_cnt", stall_cnt, 15);
    chk("err_sticky", mc_error, 1);
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    step();
    step();
    chk("rst_mid_state", state_o, 2);
    reset = 1'b1;
    #1;
    chk("rst_mid_forced", dhazard, 0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_mid_state0", state_o, 0);
    chk("rst_mid_dhazard", dhazard, 0);
    chk("rst_mid_stall", stall_cnt, 0);
    chk("rst_mid_flush", flush_cnt, 0);
    chk("rst_mid_error", mc_error, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
